// File: rtl/md_sequencer.sv
// Multiply/divide sequencer for the E stage: operand latch, fixed-latency busy window, HI/LO commit.
// Optional MADD/MADDU accumulate ops are enabled by defining MD_MADD_EN.
module md_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        D_is_md,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        md_stall
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  count_reg, count_next;
  logic [31:0] hi_reg, lo_reg;
  logic [31:0] p_hi_reg, p_lo_reg;
  logic        commit_en_reg;

  logic        is_mul, is_div, is_madd, op_run;
  logic        launch, commit;
  logic [63:0] result;

  // Op-class decode; MADD/MADDU fall into the NONE class unless enabled.
  always_comb begin
    is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
    is_div = (md_op == OP_DIV)  || (md_op == OP_DIVU);
`ifdef MD_MADD_EN
    is_madd = (md_op == OP_MADD) || (md_op == OP_MADDU);
`else
    is_madd = 1'b0;
`endif
    op_run = is_mul || is_div || is_madd;
  end

  assign launch = start && (state_reg == IDLE) && op_run;
  assign commit = (state_reg == BUSY) && (count_reg == 4'd1);

  // Datapath: one signed and one unsigned product, one shared unsigned divider.
  logic signed [63:0] rs_sx, rt_sx, prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] rs_abs, rt_abs, div_num, div_den, q_mag, r_mag, q_s, r_s;

  always_comb begin
    rs_sx  = {{32{rs_val[31]}}, rs_val};
    rt_sx  = {{32{rt_val[31]}}, rt_val};
    prod_s = rs_sx * rt_sx;
    prod_u = {32'd0, rs_val} * {32'd0, rt_val};
    rs_abs = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
    rt_abs = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
    div_num = (md_op == OP_DIV) ? rs_abs : rs_val;
    div_den = (md_op == OP_DIV) ? rt_abs : rt_val;
    // Zero divisor never commits; substitute 1 to keep the divider output defined.
    if (div_den == 32'd0) begin
      div_den = 32'd1;
    end
    q_mag = div_num / div_den;
    r_mag = div_num % div_den;
    // Magnitude division then sign fix-up gives truncation toward zero and
    // maps 0x80000000 / -1 onto quotient 0x80000000, remainder 0.
    q_s = (rs_val[31] ^ rt_val[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s = rs_val[31] ? (~r_mag + 32'd1) : r_mag;
  end

  always_comb begin
    result = 64'd0;
    unique case (md_op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV:   result = {r_s, q_s};
      OP_DIVU:  result = {r_mag, q_mag};
`ifdef MD_MADD_EN
      OP_MADD:  result = {hi_reg, lo_reg} + prod_s;
      OP_MADDU: result = {hi_reg, lo_reg} + prod_u;
`endif
      default:  result = 64'd0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state and countdown
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    if (launch) begin
      state_next = BUSY;
      count_next = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    end else if (state_reg == BUSY) begin
      count_next = count_reg - 4'd1;
      if (count_reg == 4'd1) begin
        state_next = IDLE;
      end
    end
  end

  // FSM: outputs
  always_comb begin
    busy     = (state_reg == BUSY);
    md_stall = reset && D_is_md && ((state_reg == BUSY) || (start && op_run));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg     <= 4'd0;
      hi_reg        <= 32'd0;
      lo_reg        <= 32'd0;
      p_hi_reg      <= 32'd0;
      p_lo_reg      <= 32'd0;
      commit_en_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (launch) begin
        p_hi_reg      <= result[63:32];
        p_lo_reg      <= result[31:0];
        commit_en_reg <= !(is_div && (rt_val == 32'd0));
      end
      if (commit) begin
        if (commit_en_reg) begin
          hi_reg <= p_hi_reg;
          lo_reg <= p_lo_reg;
        end
      end else if (start && (state_reg == IDLE)) begin
        if (md_op == OP_MTHI) begin
          hi_reg <= rs_val;
        end
        if (md_op == OP_MTLO) begin
          lo_reg <= rs_val;
        end
      end
    end
  end

  assign hi = hi_reg;
  assign lo = lo_reg;

endmodule
